// File: rtl/gpo_ctrl_if.sv
// Peripheral-bus slave port for gpo_ctrl: single-cycle request in, one-cycle ack and registered read data out.
interface gpo_ctrl_if;
    logic [3:0]  addr_in;
    logic [31:0] gpo_din;
    logic        gpo_req;
    logic        gpo_we;
    logic [31:0] gpo_rdata;
    logic        gpo_ack;

    modport master (
        output addr_in, gpo_din, gpo_req, gpo_we,
        input  gpo_rdata, gpo_ack
    );

    modport slave (
        input  addr_in, gpo_din, gpo_req, gpo_we,
        output gpo_rdata, gpo_ack
    );
endinterface

// File: rtl/gpo_ctrl.sv
// NBIT-line output controller: atomic set/clear/toggle, per-bit one-shot pulses, registered read-back.
// Every request is acked exactly one cycle after it is sampled; no backpressure, back-to-back requests accepted.
module gpo_ctrl #(
    parameter int NBIT     = 4,
    parameter int PW       = 8,
    parameter int PLEN_RST = 1
) (
    input  logic            clk,
    input  logic            resetn,
    gpo_ctrl_if.slave       bus,
    output logic [NBIT-1:0] gpo_dout
);

    localparam logic [3:0] A_OUT    = 4'h0;
    localparam logic [3:0] A_SET    = 4'h1;
    localparam logic [3:0] A_CLR    = 4'h2;
    localparam logic [3:0] A_TGL    = 4'h3;
    localparam logic [3:0] A_PULSE  = 4'h4;
    localparam logic [3:0] A_PLEN   = 4'h5;
    localparam logic [3:0] A_STATUS = 4'h6;

    localparam logic [PW-1:0] CNT_ONE = PW'(1);

    logic [NBIT-1:0]         dout_q, dout_d;
    logic [NBIT-1:0][PW-1:0] cnt_q, cnt_d;
    logic [PW-1:0]           plen_q, plen_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    ack_q, ack_d;

    logic                    wr, rd;
    logic [NBIT-1:0]         din_n;
    logic [NBIT-1:0]         busy;
    logic [PW-1:0]           plen_load;
    logic                    unused_din;

    assign wr         = bus.gpo_req &  bus.gpo_we;
    assign rd         = bus.gpo_req & ~bus.gpo_we;
    assign din_n      = bus.gpo_din[NBIT-1:0];
    assign unused_din = ^bus.gpo_din;
    // A zero PLEN still produces a one-cycle pulse.
    assign plen_load  = (plen_q == '0) ? CNT_ONE : plen_q;

    always_comb begin
        for (int i = 0; i < NBIT; i++) begin
            busy[i] = (cnt_q[i] != '0);
        end
    end

    // Pulse engines count down first; any bus write touching a bit then overrides it.
    always_comb begin
        dout_d = dout_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < NBIT; i++) begin
            if (busy[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
                if (cnt_q[i] == CNT_ONE) begin
                    dout_d[i] = 1'b0;
                end
            end
        end
        if (wr) begin
            case (bus.addr_in)
                A_OUT: begin
                    dout_d = din_n;
                    cnt_d  = '0;
                end
                A_SET, A_CLR, A_TGL, A_PULSE: begin
                    for (int i = 0; i < NBIT; i++) begin
                        if (din_n[i]) begin
                            cnt_d[i] = '0;
                            case (bus.addr_in)
                                A_SET:   dout_d[i] = 1'b1;
                                A_CLR:   dout_d[i] = 1'b0;
                                A_TGL:   dout_d[i] = ~dout_q[i];
                                default: begin
                                    dout_d[i] = 1'b1;
                                    cnt_d[i]  = plen_load;
                                end
                            endcase
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        plen_d = plen_q;
        if (wr && (bus.addr_in == A_PLEN)) begin
            plen_d = bus.gpo_din[PW-1:0];
        end
    end

    // Read data reflects pre-edge state and is held between reads.
    always_comb begin
        rdata_d = rdata_q;
        ack_d   = bus.gpo_req;
        if (rd) begin
            rdata_d = '0;
            case (bus.addr_in)
                A_OUT, A_SET, A_CLR, A_TGL: rdata_d[NBIT-1:0] = dout_q;
                A_PULSE:                    rdata_d[NBIT-1:0] = busy;
                A_PLEN:                     rdata_d[PW-1:0]   = plen_q;
                A_STATUS:                   rdata_d[0]        = |busy;
                default:                    rdata_d           = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dout_q  <= '0;
            cnt_q   <= '0;
            plen_q  <= PW'(PLEN_RST);
            rdata_q <= '0;
            ack_q   <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            plen_q  <= plen_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
        end
    end

    assign gpo_dout      = dout_q;
    assign bus.gpo_rdata = rdata_q;
    assign bus.gpo_ack   = ack_q;

endmodule

// File: tb/tb_gpo_ctrl.sv
// Directed bench for gpo_ctrl: stimulus pushes expected ack-cycle results, a negedge monitor pops and compares.
module tb_gpo_ctrl;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [3:0] gpo_dout;

    gpo_ctrl_if bus ();

    gpo_ctrl #(.NBIT(4), .PW(8), .PLEN_RST(1)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .bus      (bus),
        .gpo_dout (gpo_dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_rd;
        logic [3:0]  addr;
        logic [31:0] rd;
        logic [3:0]  dout;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   stall = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every ack consumes one expectation; a pending one with no ack is a timeout.
    always @(negedge clk) begin
        if (resetn) begin
            if (bus.gpo_ack) begin
                stall = 0;
                if (q.size() == 0) begin
                    check("spurious_ack", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (e.is_rd) check($sformatf("rdata@%0h", e.addr), bus.gpo_rdata, e.rd);
                    check($sformatf("dout@%0h", e.addr), {28'd0, gpo_dout}, {28'd0, e.dout});
                end
            end else if (q.size() != 0) begin
                stall++;
                if (stall > 1) begin
                    check("ack_timeout", 32'd0, 32'd1);
                    void'(q.pop_front());
                    stall = 0;
                end
            end
        end else begin
            stall = 0;
        end
    end

    task automatic op(input logic we, input logic [3:0] a, input logic [31:0] d,
                      input logic [31:0] erd, input logic [3:0] edo);
        exp_t e;
        @(negedge clk);
        bus.gpo_req = 1'b1;
        bus.gpo_we  = we;
        bus.addr_in = a;
        bus.gpo_din = d;
        e.is_rd = !we;
        e.addr  = a;
        e.rd    = erd;
        e.dout  = edo;
        q.push_back(e);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] edo);
        op(1'b1, a, d, 32'd0, edo);
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] erd, input logic [3:0] edo);
        op(1'b0, a, 32'hDEAD_BEEF, erd, edo);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.gpo_req = 1'b0;
            bus.gpo_we  = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.gpo_req = 1'b0;
        bus.gpo_we  = 1'b0;
        bus.addr_in = 4'h0;
        bus.gpo_din = 32'h0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        #1;
        check("rst_dout",  {28'd0, gpo_dout}, 32'd0);
        check("rst_rdata", bus.gpo_rdata, 32'd0);
        check("rst_ack",   {31'd0, bus.gpo_ack}, 32'd0);

        // Reset PLEN, then the set/clear/toggle walk.
        rd(4'h5, 32'd1, 4'h0);
        wr(4'h0, 32'hA, 4'hA);
        wr(4'h1, 32'h1, 4'hB);
        wr(4'h2, 32'h8, 4'h3);
        wr(4'h3, 32'hF, 4'hC);
        rd(4'h0, 32'hC, 4'hC);
        rd(4'h1, 32'hC, 4'hC);
        rd(4'h2, 32'hC, 4'hC);
        rd(4'h3, 32'hC, 4'hC);

        // PLEN=5 pulse on bit1: high after T..T+4, low from T+5.
        wr(4'h5, 32'd5, 4'hC);
        wr(4'h4, 32'h2, 4'hE);
        rd(4'h4, 32'h2, 4'hE);
        rd(4'h4, 32'h2, 4'hE);
        rd(4'h4, 32'h2, 4'hE);
        rd(4'h4, 32'h2, 4'hE);
        rd(4'h4, 32'h2, 4'hC);
        rd(4'h4, 32'h0, 4'hC);
        rd(4'h6, 32'h0, 4'hC);

        // Retrigger at T+2 with PLEN=4: six cycles high.
        wr(4'h0, 32'h0, 4'h0);
        wr(4'h5, 32'd4, 4'h0);
        wr(4'h4, 32'h1, 4'h1);
        rd(4'h4, 32'h1, 4'h1);
        wr(4'h4, 32'h1, 4'h1);
        rd(4'h4, 32'h1, 4'h1);
        rd(4'h4, 32'h1, 4'h1);
        rd(4'h4, 32'h1, 4'h1);
        rd(4'h4, 32'h1, 4'h0);
        rd(4'h4, 32'h0, 4'h0);

        // Cancel by CLR one cycle after trigger.
        wr(4'h4, 32'h1, 4'h1);
        wr(4'h2, 32'h1, 4'h0);
        rd(4'h4, 32'h0, 4'h0);
        rd(4'h6, 32'h0, 4'h0);

        // SET on the expiry edge wins.
        wr(4'h5, 32'd3, 4'h0);
        wr(4'h4, 32'h4, 4'h4);
        rd(4'h6, 32'h1, 4'h4);
        rd(4'h4, 32'h4, 4'h4);
        wr(4'h1, 32'h4, 4'h4);
        rd(4'h4, 32'h0, 4'h4);
        rd(4'h0, 32'h4, 4'h4);

        // PLEN=0 gives a one-cycle pulse.
        wr(4'h0, 32'h0, 4'h0);
        wr(4'h5, 32'h0, 4'h0);
        rd(4'h5, 32'h0, 4'h0);
        wr(4'h4, 32'h8, 4'h8);
        rd(4'h4, 32'h8, 4'h0);
        rd(4'h4, 32'h0, 4'h0);

        // PLEN truncation and unmapped/status accesses.
        wr(4'h5, 32'h1FF, 4'h0);
        rd(4'h5, 32'hFF, 4'h0);
        wr(4'h0, 32'h5, 4'h5);
        wr(4'h9, 32'hF, 4'h5);
        rd(4'h9, 32'h0, 4'h5);
        rd(4'h7, 32'h0, 4'h5);
        rd(4'h0, 32'h5, 4'h5);
        rd(4'h5, 32'hFF, 4'h5);
        wr(4'h6, 32'hF, 4'h5);
        rd(4'h6, 32'h0, 4'h5);
        idle(1);
        check("rdata_hold", bus.gpo_rdata, 32'h0);

        // Asynchronous reset in the middle of a pulse.
        wr(4'h5, 32'd5, 4'h5);
        wr(4'h4, 32'h2, 4'h7);
        idle(2);
        check("drain_pre_reset", q.size(), 32'd0);
        #2;
        check("pulse_before_reset", {28'd0, gpo_dout}, 32'h7);
        resetn = 1'b0;
        #1;
        check("async_rst_dout",  {28'd0, gpo_dout}, 32'd0);
        check("async_rst_ack",   {31'd0, bus.gpo_ack}, 32'd0);
        check("async_rst_rdata", bus.gpo_rdata, 32'd0);
        @(negedge clk);
        #2;
        resetn = 1'b1;
        rd(4'h4, 32'h0, 4'h0);
        rd(4'h5, 32'h1, 4'h0);
        idle(3);
        check("drain_end", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
